// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, types and helpers for the instruction fetch path.
//   PC_W / INST_W  : ROM address and instruction widths (1024 x 9-bit ROM)
//   LUT_DEPTH      : number of absolute branch-target entries
//   START_PC       : PC used on reset and every (re)start
//   state_t        : sequencer FSM states
//   rel_target()   : PC-relative target with sign-extended 8-bit offset
package fetch_pkg;

  localparam int PC_W      = 10;
  localparam int INST_W    = 9;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [INST_W-1:0]    inst_t;
  typedef logic [LUT_IDX_W-1:0] lut_idx_t;

  localparam pc_t START_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  // Sum wraps naturally at PC_W bits, so negative offsets and
  // end-of-ROM targets need no special handling.
  function automatic pc_t rel_target(input pc_t base, input logic [7:0] offset);
    return base + pc_t'({{(PC_W-8){offset[7]}}, offset});
  endfunction

endpackage

// File: rtl/fetch_sequencer_jump_lut.sv
// jump_lut: 16-entry register file of absolute branch targets.
//   clk, rst_n : clock, async active-low reset (clears all entries)
//   we, waddr, wdata : single write port, applied on the rising edge
//   raddr, rdata     : combinational read port; returns the pre-write
//                      value when reading the entry being written
module jump_lut
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);

  pc_t lut_q [LUT_DEPTH];
  pc_t lut_d [LUT_DEPTH];

  always_comb begin
    lut_d = lut_q;
    if (we) lut_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else begin
      lut_q <= lut_d;
    end
  end

  // Reads the registered array, so a same-cycle write is not visible yet.
  assign rdata = lut_q[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller for the instruction ROM.
//   start / halt_req        : run control (IDLE -> RUN <-> HALTED)
//   inst_addr / inst_in     : ROM address out, combinational ROM data in
//   ir_data/ir_pc/ir_valid  : instruction register towards decode,
//                             handed over with ir_ready
//   br_*                    : redirect for the instruction in IR, relative
//                             or via the absolute target LUT
//   lut_we/waddr/wdata      : target LUT write port
//   halted                  : sequencer is in HALTED
// Optional: define FETCH_PERF_EN to add the 16-bit saturating output
// fetch_count of instructions accepted by decode since entering RUN.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  output logic [PC_W-1:0]      inst_addr,
  input  logic [INST_W-1:0]    inst_in,
  output logic [INST_W-1:0]    ir_data,
  output logic [PC_W-1:0]      ir_pc,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  input  logic                 br_taken,
  input  logic                 br_rel,
  input  logic [7:0]           br_offset,
  input  logic [LUT_IDX_W-1:0] br_lut_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic                 halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]          fetch_count
`endif
);

  state_t state_q, state_d;
  pc_t    fetch_pc_q, fetch_pc_d;
  inst_t  ir_data_q, ir_data_d;
  pc_t    ir_pc_q, ir_pc_d;
  logic   ir_valid_q, ir_valid_d;
  logic   halted_q, halted_d;
  pc_t    lut_rdata;
  pc_t    br_target;
  logic   enter_run;

  jump_lut u_jump_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (br_lut_idx),
    .rdata (lut_rdata)
  );

  assign enter_run = (state_q != RUN) && start;
  assign br_target = br_rel ? rel_target(ir_pc_q, br_offset) : lut_rdata;

  // Priority inside RUN: halt, then branch (only with a valid IR), then load.
  // A pending br_taken also blocks the load even when IR is empty.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d    = RUN;
          fetch_pc_d = START_PC;
          ir_valid_d = 1'b0;
          halted_d   = 1'b0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d    = HALTED;
          ir_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (br_taken && ir_valid_q) begin
          fetch_pc_d = br_target;
          ir_valid_d = 1'b0;
        end else if (!br_taken && (!ir_valid_q || ir_ready)) begin
          ir_data_d  = inst_in;
          ir_pc_d    = fetch_pc_q;
          ir_valid_d = 1'b1;
          fetch_pc_d = fetch_pc_q + pc_t'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= START_PC;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign inst_addr = fetch_pc_q;
  assign ir_data   = ir_data_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // Counts decode handshakes; a handshake coinciding with halt_req is
  // discarded by the halt and therefore not counted.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (enter_run) begin
      fetch_count_d = '0;
    end else if (state_q == RUN && ir_valid_q && ir_ready && !halt_req &&
                 fetch_count_q != 16'hFFFF) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count_q <= '0;
    else        fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed test of fetch_sequencer against a
// behavioural ROM whose word at address a is {1'b1, a[7:0] + 1}.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       halt_req;
  logic [9:0] inst_addr;
  logic [8:0] inst_in;
  logic [8:0] ir_data;
  logic [9:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;
  logic       br_taken;
  logic       br_rel;
  logic [7:0] br_offset;
  logic [3:0] br_lut_idx;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .inst_addr  (inst_addr),
    .inst_in    (inst_in),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .br_taken   (br_taken),
    .br_rel     (br_rel),
    .br_offset  (br_offset),
    .br_lut_idx (br_lut_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] romModel(input logic [9:0] a);
    return {1'b1, a[7:0] + 8'd1};
  endfunction

  assign inst_in = romModel(inst_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sets the run/branch controls for the next edge and advances one cycle.
  task automatic applyStimulus(input logic st, input logic hr, input logic br,
                               input logic rel, input logic [7:0] off,
                               input logic [3:0] idx);
    start      = st;
    halt_req   = hr;
    br_taken   = br;
    br_rel     = rel;
    br_offset  = off;
    br_lut_idx = idx;
    tick();
  endtask

  task automatic checkIr(input string tag, input logic [9:0] pc, input logic [8:0] data);
    checkOutput({tag, ".valid"}, ir_valid, 1'b1);
    checkOutput({tag, ".pc"}, ir_pc, pc);
    checkOutput({tag, ".data"}, ir_data, data);
  endtask

  task automatic checkBubble(input string tag, input logic [9:0] addr);
    checkOutput({tag, ".valid"}, ir_valid, 1'b0);
    checkOutput({tag, ".addr"}, inst_addr, addr);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; halt_req = 0; ir_ready = 0; br_taken = 0;
    br_rel = 0; br_offset = '0; br_lut_idx = '0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    #12;
    checkOutput("rst.valid", ir_valid, 1'b0);
    checkOutput("rst.halted", halted, 1'b0);
    checkOutput("rst.addr", inst_addr, 10'd0);
    checkOutput("rst.pc", ir_pc, 10'd0);
    checkOutput("rst.data", ir_data, 9'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Preload lut[1]=1020 and lut[2]=8 while idle
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 10'h3FC; tick();
    lut_waddr = 4'd2; lut_wdata = 10'd8; tick();
    lut_we = 0;
    checkOutput("idle.valid", ir_valid, 1'b0);

    // Start: RUN at this edge, first instruction one edge later
    applyStimulus(1, 0, 0, 0, 8'h00, 4'd0);
    checkBubble("start", 10'd0);
    ir_ready = 1;
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("seq0", 10'd0, 9'h101);
    tick(); checkIr("seq1", 10'd1, 9'h102);
    tick(); checkIr("seq2", 10'd2, 9'h103);
    tick(); checkIr("seq3", 10'd3, 9'h104);
    tick(); tick();
    checkIr("seq5", 10'd5, 9'h106);

    // Stall three cycles with ir_pc=5
    ir_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIr("stall", 10'd5, 9'h106);
      checkOutput("stall.addr", inst_addr, 10'd6);
    end
    ir_ready = 1;
    // start while running must be ignored
    applyStimulus(1, 0, 0, 0, 8'h00, 4'd0);
    checkIr("resume", 10'd6, 9'h107);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("norestart", 10'd7, 9'h108);
    tick(); tick(); tick();
    checkIr("seq10", 10'd10, 9'h10B);

    // Relative branch -4 from 10
    applyStimulus(0, 0, 1, 1, 8'hFC, 4'd0);
    checkBubble("brneg", 10'd6);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("brneg.tgt", 10'd6, 9'h107);

    // LUT branch to 1020, then relative +7 wraps to 3
    applyStimulus(0, 0, 1, 0, 8'h00, 4'd1);
    checkBubble("brlut1", 10'h3FC);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("brlut1.tgt", 10'd1020, 9'h1FD);
    applyStimulus(0, 0, 1, 1, 8'h07, 4'd0);
    checkBubble("brwrap", 10'd3);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("brwrap.tgt", 10'd3, 9'h104);

    // Sequential wrap 1023 -> 0
    applyStimulus(0, 0, 1, 0, 8'h00, 4'd1);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    tick(); tick(); tick();
    checkIr("pc1023", 10'd1023, 9'h100);
    tick();
    checkIr("pcwrap", 10'd0, 9'h101);

    // lut[3]=0x2A0, then branch via lut[3] while rewriting it
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h2A0;
    tick();
    checkIr("lutwr", 10'd1, 9'h102);
    lut_wdata = 10'h155;
    applyStimulus(0, 0, 1, 0, 8'h00, 4'd3);
    lut_we = 0;
    checkBubble("brlut3", 10'h2A0);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("brlut3.tgt", 10'h2A0, 9'h1A1);
    applyStimulus(0, 0, 1, 0, 8'h00, 4'd3);
    checkBubble("brlut3b", 10'h155);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("brlut3b.tgt", 10'h155, 9'h156);

    // Reach ir_pc=8, then halt with a simultaneous branch
    applyStimulus(0, 0, 1, 0, 8'h00, 4'd2);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("pc8", 10'd8, 9'h109);
    applyStimulus(0, 1, 1, 1, 8'h04, 4'd0);
    checkOutput("halt.halted", halted, 1'b1);
    checkBubble("halt", 10'd9);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    tick();
    checkOutput("halted.hold", halted, 1'b1);
    checkBubble("halted.hold", 10'd9);

    // Restart from START_PC
    applyStimulus(1, 0, 0, 0, 8'h00, 4'd0);
    checkOutput("restart.halted", halted, 1'b0);
    checkBubble("restart", 10'd0);
    applyStimulus(0, 0, 0, 0, 8'h00, 4'd0);
    checkIr("restart0", 10'd0, 9'h101);
`ifdef FETCH_PERF_EN
    checkOutput("perf.zero", fetch_count, 16'd0);
`endif
    tick(); tick(); tick(); tick();
    checkIr("restart4", 10'd4, 9'h105);
`ifdef FETCH_PERF_EN
    checkOutput("perf.four", fetch_count, 16'd4);
`endif

    // Asynchronous reset mid-RUN, away from any clock edge
    rst_n = 1'b0;
    #2;
    checkOutput("arst.valid", ir_valid, 1'b0);
    checkOutput("arst.addr", inst_addr, 10'd0);
    checkOutput("arst.pc", ir_pc, 10'd0);
    checkOutput("arst.data", ir_data, 9'd0);
    checkOutput("arst.halted", halted, 1'b0);
`ifdef FETCH_PERF_EN
    checkOutput("arst.perf", fetch_count, 16'd0);
`endif
    #10;
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller for the 1024 x 9-bit instruction ROM.
- Drives the ROM address, captures the returned instruction into an instruction register (IR), and hands it to decode over a valid/ready handshake.
- Handles start, halt and stall, and redirects on branches: PC-relative, or absolute through a 16-entry target LUT, because a 9-bit instruction cannot encode a 10-bit address.

Parameters:
- PC_W, 10, ROM address width.
- INST_W, 9, instruction width.
- LUT_DEPTH, 16, number of absolute-target LUT entries.
- START_PC, 0, PC loaded on reset and on every start.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins fetching at START_PC.
- halt_req  in  1  stop fetching.
- inst_addr  out  PC_W  address to the ROM.
- inst_in  in  INST_W  ROM data; combinational from inst_addr in the same cycle.
- ir_data  out  INST_W  registered instruction to decode.
- ir_pc  out  PC_W  address of the instruction in ir_data.
- ir_valid  out  1  ir_data is valid.
- ir_ready  in  1  decode accepts ir_data.
- br_taken  in  1  redirect request, resolved for the instruction in IR.
- br_rel  in  1  1 = relative target, 0 = LUT target.
- br_offset  in  8  signed relative offset.
- br_lut_idx  in  4  LUT index.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  4  LUT write index.
- lut_wdata  in  PC_W  LUT write data.
- halted  out  1  sequencer is in HALTED.

Behaviour:
- Reset (async, any state): state=IDLE, fetch_pc=START_PC, ir_data=0, ir_pc=0, ir_valid=0, halted=0, all LUT entries=0.
- inst_addr = fetch_pc at all times.
- States:
  - IDLE: start -> RUN.
  - RUN: halt_req -> HALTED.
  - HALTED: start -> RUN.
  - No other transitions.
- Entering RUN (from IDLE or HALTED): fetch_pc=START_PC, ir_valid=0, halted=0.
- Latency: start sampled at edge n -> RUN from n; ir_valid=1 with ROM[START_PC] after edge n+1.
- Load condition in RUN: (!ir_valid || ir_ready) && !br_taken && !halt_req.
  - On load: ir_data<=inst_in, ir_pc<=fetch_pc, ir_valid<=1, fetch_pc<=fetch_pc+1.
- Stall: ir_valid && !ir_ready -> ir_data, ir_pc and fetch_pc all hold.
- Wrap-around: fetch_pc+1 is taken mod 2^PC_W, so 1023 -> 0. No error is flagged.
- Branch: br_taken is honoured only in RUN with ir_valid=1, whether or not ir_ready is high.
  - fetch_pc <= target.
  - ir_valid <= 0, a one-cycle flush bubble. The IR instruction counts as consumed.
  - Relative target: (ir_pc + sign_extend(br_offset)) mod 2^PC_W.
  - LUT target: lut[br_lut_idx].
  - br_taken with ir_valid=0 is ignored.
- Halt: halt_req in RUN -> HALTED next edge.
  - ir_valid <= 0 and halted <= 1; the pending IR is discarded.
  - halt_req wins over a simultaneous br_taken and over a load.
- start while in RUN is ignored. halt_req outside RUN is ignored.
- LUT write: lut_we writes lut[lut_waddr] on the edge, in any state.
  - A same-cycle read at the write index returns the old value.
- In IDLE and HALTED: fetch_pc holds, ir_valid=0, and the ROM is not sequenced.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count (16 bits).
  - Increments on every ir_valid && ir_ready edge that is not flushed by halt_req.
  - Saturates at 0xFFFF.
  - Cleared by reset and on entry to RUN.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- fetch_pkg:
  - State enum: IDLE, RUN, HALTED.
  - PC_W, INST_W, LUT_DEPTH, START_PC defaults.
  - pc_t and inst_t typedefs.
- Sub-module jump_lut:
  - 16 x PC_W register file, async-reset to 0.
  - One write port, one combinational read port.
- fetch_sequencer holds the FSM, the PC, the IR and the target mux.

Test Plan:
- Reset then start, ir_ready=1, ROM[0..3] = 9'h101, 9'h102, 9'h103, 9'h104 -> ir_valid rises one edge after RUN entry; ir_data follows that sequence on consecutive cycles with ir_pc = 0, 1, 2, 3.
- ir_ready held low 3 cycles while ir_pc=5 -> ir_data, ir_pc and inst_addr=6 stay constant; ir_pc=6 is presented the cycle after ir_ready rises.
- ir_pc=10, br_taken=1, br_rel=1, br_offset=-4 -> one ir_valid=0 bubble, then ir_pc=6. ir_pc=1020, offset=+7 -> ir_pc=3 (wrap).
- Write lut[3]=10'h2A0, then branch with br_rel=0, br_lut_idx=3 -> next valid ir_pc=0x2A0. A same-cycle write to lut[3] must not affect that branch.
- halt_req and br_taken together at ir_pc=8 -> halted=1 and ir_valid=0 next edge. A later start restarts at ir_pc=START_PC, and halted clears.
- rst_n asserted mid-RUN with ir_valid=1 -> all outputs return to reset values immediately without waiting for clk. With FETCH_PERF_EN, fetch_count=0 after reset, and equals 4 after four accepted instructions.
